axi4s_width_conv_arb: RTL



---
 rtl/axi4s_arb_pkg.sv | 35 +++
 rtl/axi4s_rr_arbiter.sv | 36 +++
 rtl/axi4s_width_conv_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/axi4s_arb_pkg.sv
// Shared types and the round-robin pick helper
// for the packet-level stream arbiter.
package axi4s_arb_pkg;

  typedef enum logic {ARB, PASS} arb_state_t;

  localparam int MAX_N = 16;
  localparam int MAX_W = 4;

  typedef struct packed {
    logic             found;
    logic [MAX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req searching upward from last+1, wrapping at n.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_N-1:0] req,
    input logic [MAX_W-1:0] last,
    input int               n
  );
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 1; i <= MAX_N; i++) begin
      k = int'(last) + i;
      if (k >= n) k = k - n;
      if (i <= n && !r.found && req[k[MAX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = k[MAX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4s_rr_arbiter.sv
// Combinational round-robin pick with a registered
// last-winner pointer; reusable by other stream muxes.
module axi4s_rr_arbiter
  import axi4s_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_update,
  input  logic [IDX_W-1:0] i_grant,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] r_last;
  rr_pick_t         w_pick;
  logic             w_unused;

  // Reset to N-1 so input 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IDX_W'(N - 1);
    end else if (i_update) begin
      r_last <= i_grant;
    end
  end

  assign w_pick   = rr_pick(MAX_N'(i_req), MAX_W'(r_last), N);
  assign o_found  = w_pick.found;
  assign o_idx    = w_pick.idx[IDX_W-1:0];
  assign w_unused = ^w_pick.idx;

endmodule

// File: rtl/axi4s_width_conv_arb.sv
// Packet-level round-robin arbiter in front of a shared
// AXI4-Stream width converter; tdest carries the source index.
module axi4s_width_conv_arb
  import axi4s_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_INPUTS-1:0]             cfg_enable,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_INPUTS*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_INPUTS-1:0]             s_tlast,
  input  logic [NUM_INPUTS-1:0]             s_tvalid,
  output logic [NUM_INPUTS-1:0]             s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_tkeep,
  output logic                              m_tlast,
  output logic [IDX_W-1:0]                  m_tdest,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              busy
);

  localparam int KW = DATA_WIDTH / 8;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_found;
  logic             w_load_en;
  logic             w_accept;
  logic             w_acc_last;

  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KW-1:0]         w_sel_keep;

  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KW-1:0]         r_tkeep;
  logic                  r_tlast;
  logic [IDX_W-1:0]      r_tdest;
  logic                  r_tvalid;

  axi4s_rr_arbiter #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (s_tvalid & cfg_enable),
    .i_update (w_acc_last),
    .i_grant  (r_grant),
    .o_found  (w_found),
    .o_idx    (w_pick_idx)
  );

  assign w_load_en = !r_tvalid | m_tready;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (r_grant == IDX_W'(k)) begin
        w_sel_valid = s_tvalid[k];
        w_sel_last  = s_tlast[k];
        w_sel_data  = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep  = s_tkeep[k*KW +: KW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_tready    = '0;
    w_accept    = 1'b0;
    unique case (r_state)
      ARB: begin
        if (w_found) w_state_nxt = PASS;
      end
      PASS: begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          s_tready[k] = w_load_en && (r_grant == IDX_W'(k));
        end
        w_accept = w_load_en & w_sel_valid;
        if (w_accept && w_sel_last) w_state_nxt = ARB;
      end
    endcase
  end

  assign w_acc_last = w_accept & w_sel_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB && w_found) r_grant <= w_pick_idx;
    end
  end

  // Single output stage; holds steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tdest  <= '0;
      r_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_tdata  <= w_sel_data;
      r_tkeep  <= w_sel_keep;
      r_tlast  <= w_sel_last;
      r_tdest  <= r_grant;
      r_tvalid <= 1'b1;
    end else if (w_load_en) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_tdata  = r_tdata;
  assign m_tkeep  = r_tkeep;
  assign m_tlast  = r_tlast;
  assign m_tdest  = r_tdest;
  assign m_tvalid = r_tvalid;
  assign busy     = (r_state == PASS) | r_tvalid;

endmodule
